// File: rtl/vect_reg_arbiter_if.sv
// Requester and bank-pin bundle for the vector register bank arbiter.
// The arbiter takes the slave modport; requesters and the bank side take master.
interface vect_reg_arbiter_if;
   logic        rd_req0, rd_req1;
   logic [2:0]  rd_a0, rd_b0, rd_a1, rd_b1;
   logic        rd_gnt0, rd_gnt1;
   logic        rd_vld0, rd_vld1;
   logic        wr_req0, wr_req1;
   logic [2:0]  wr_dir0, wr_dir1;
   logic [63:0] wr_data0, wr_data1;
   logic        wr_gnt0, wr_gnt1;
   logic [2:0]  bank_dir_A, bank_dir_B;
   logic        bank_signal_read;
   logic [2:0]  bank_dir_esc;
   logic [63:0] bank_data;
   logic        bank_signal_esc;

   modport slave (
      input  rd_req0, rd_req1, rd_a0, rd_b0, rd_a1, rd_b1,
      input  wr_req0, wr_req1, wr_dir0, wr_dir1, wr_data0, wr_data1,
      output rd_gnt0, rd_gnt1, rd_vld0, rd_vld1, wr_gnt0, wr_gnt1,
      output bank_dir_A, bank_dir_B, bank_signal_read,
      output bank_dir_esc, bank_data, bank_signal_esc
   );

   modport master (
      output rd_req0, rd_req1, rd_a0, rd_b0, rd_a1, rd_b1,
      output wr_req0, wr_req1, wr_dir0, wr_dir1, wr_data0, wr_data1,
      input  rd_gnt0, rd_gnt1, rd_vld0, rd_vld1, wr_gnt0, wr_gnt1,
      input  bank_dir_A, bank_dir_B, bank_signal_read,
      input  bank_dir_esc, bank_data, bank_signal_esc
   );
endinterface

// File: rtl/vect_reg_arbiter.sv
// Shares the 8x64 vector register bank between the vector ALU (port 0) and the
// load/store unit (port 1): round-robin reads, port-0-priority writes with a starvation guard.
module vect_reg_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input logic               clk,
   input logic               rst_n,
   vect_reg_arbiter_if.slave bus
);
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned DATA_W = 64;

   logic             rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             rd_vld0_q, rd_vld0_d;
   logic             rd_vld1_q, rd_vld1_d;

   logic              rd_gnt0_c, rd_gnt1_c;
   logic              wr_gnt0_c, wr_gnt1_c;
   logic              starve_hit_c;
   logic [IDX_W-1:0]  dir_a_c, dir_b_c, dir_esc_c;
   logic [DATA_W-1:0] data_c;

   // Grants are a function of current requests and registered state only; forced low in reset.
   always_comb begin
      rd_gnt0_c    = 1'b0;
      rd_gnt1_c    = 1'b0;
      wr_gnt0_c    = 1'b0;
      wr_gnt1_c    = 1'b0;
      starve_hit_c = 1'b0;
      if (rst_n) begin
         rd_gnt0_c    = bus.rd_req0 & (~bus.rd_req1 | ~rr_ptr_q);
         rd_gnt1_c    = bus.rd_req1 & (~bus.rd_req0 |  rr_ptr_q);
         starve_hit_c = bus.wr_req1 & (starve_cnt_q == CNT_W'(STARVE_MAX));
         wr_gnt0_c    = bus.wr_req0 & ~starve_hit_c;
         wr_gnt1_c    = bus.wr_req1 & (~bus.wr_req0 | starve_hit_c);
      end
   end

   // Bank pin muxes: granted port's operands, zero when idle.
   always_comb begin
      dir_a_c   = '0;
      dir_b_c   = '0;
      dir_esc_c = '0;
      data_c    = '0;
      if (rd_gnt0_c) begin
         dir_a_c = bus.rd_a0;
         dir_b_c = bus.rd_b0;
      end else if (rd_gnt1_c) begin
         dir_a_c = bus.rd_a1;
         dir_b_c = bus.rd_b1;
      end
      if (wr_gnt0_c) begin
         dir_esc_c = bus.wr_dir0;
         data_c    = bus.wr_data0;
      end else if (wr_gnt1_c) begin
         dir_esc_c = bus.wr_dir1;
         data_c    = bus.wr_data1;
      end
   end

   // Next state: pointer moves to the loser, starvation counter saturates at STARVE_MAX.
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      starve_cnt_d = starve_cnt_q;
      rd_vld0_d    = rd_gnt0_c;
      rd_vld1_d    = rd_gnt1_c;
      if (rd_gnt0_c) begin
         rr_ptr_d = 1'b1;
      end else if (rd_gnt1_c) begin
         rr_ptr_d = 1'b0;
      end
      if (!bus.wr_req1 || wr_gnt1_c) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != CNT_W'(STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q     <= 1'b0;
         starve_cnt_q <= '0;
         rd_vld0_q    <= 1'b0;
         rd_vld1_q    <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         starve_cnt_q <= starve_cnt_d;
         rd_vld0_q    <= rd_vld0_d;
         rd_vld1_q    <= rd_vld1_d;
      end
   end

   assign bus.rd_gnt0          = rd_gnt0_c;
   assign bus.rd_gnt1          = rd_gnt1_c;
   assign bus.wr_gnt0          = wr_gnt0_c;
   assign bus.wr_gnt1          = wr_gnt1_c;
   assign bus.rd_vld0          = rd_vld0_q;
   assign bus.rd_vld1          = rd_vld1_q;
   assign bus.bank_signal_read = rd_gnt0_c | rd_gnt1_c;
   assign bus.bank_dir_A       = dir_a_c;
   assign bus.bank_dir_B       = dir_b_c;
   assign bus.bank_signal_esc  = wr_gnt0_c | wr_gnt1_c;
   assign bus.bank_dir_esc     = dir_esc_c;
   assign bus.bank_data        = data_c;
endmodule

// File: tb/tb_vect_reg_arbiter.sv
// Directed bench for vect_reg_arbiter with a behavioural 8x64 register bank attached.
module tb_vect_reg_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   vect_reg_arbiter_if bus ();

   vect_reg_arbiter #(.STARVE_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank model: write on falling edge, registered vA/vB updated only on signal_read.
   logic [63:0] mem [8];
   logic [63:0] va, vb;
   always @(negedge clk) begin
      if (bus.bank_signal_esc) mem[bus.bank_dir_esc] <= bus.bank_data;
   end
   always @(posedge clk) begin
      if (bus.bank_signal_read) begin
         va <= mem[bus.bank_dir_A];
         vb <= mem[bus.bank_dir_B];
      end
   end

   typedef struct {
      logic rq0, rq1, wq0, wq1;
      logic rg0, rg1, wg0, wg1, v0, v1;
   } vec_t;

   function automatic vec_t mk(input logic [9:0] b);
      vec_t v;
      v.rq0 = b[9]; v.rq1 = b[8]; v.wq0 = b[7]; v.wq1 = b[6];
      v.rg0 = b[5]; v.rg1 = b[4]; v.wg0 = b[3]; v.wg1 = b[2];
      v.v0  = b[1]; v.v1  = b[0];
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.rd_req0 = 0; bus.rd_req1 = 0; bus.wr_req0 = 0; bus.wr_req1 = 0;
      bus.rd_a0 = 0; bus.rd_b0 = 0; bus.rd_a1 = 0; bus.rd_b1 = 0;
      bus.wr_dir0 = 0; bus.wr_dir1 = 0; bus.wr_data0 = '0; bus.wr_data1 = '0;
   endtask

   vec_t tbl [19];

   initial begin
      checks = 0;
      errors = 0;
      // {rq0 rq1 wq0 wq1 | rg0 rg1 wg0 wg1 | v0 v1}
      tbl[0]  = mk(10'b1111_1010_00);
      tbl[1]  = mk(10'b1111_0110_10);
      tbl[2]  = mk(10'b1111_1010_01);
      tbl[3]  = mk(10'b1111_0110_10);
      tbl[4]  = mk(10'b0011_0001_01);
      tbl[5]  = mk(10'b0111_0110_00);
      tbl[6]  = mk(10'b1111_1010_01);
      tbl[7]  = mk(10'b1011_1010_10);
      tbl[8]  = mk(10'b1111_0110_10);
      tbl[9]  = mk(10'b0011_0001_01);
      tbl[10] = mk(10'b0010_0010_00);
      tbl[11] = mk(10'b0001_0001_00);
      tbl[12] = mk(10'b0011_0010_00);
      tbl[13] = mk(10'b0010_0010_00);
      tbl[14] = mk(10'b0011_0010_00);
      tbl[15] = mk(10'b0011_0010_00);
      tbl[16] = mk(10'b0011_0010_00);
      tbl[17] = mk(10'b0011_0010_00);
      tbl[18] = mk(10'b0011_0001_00);

      // Reset with everything requesting and nonzero operands.
      rst_n = 1'b0;
      bus.rd_req0 = 1; bus.rd_req1 = 1; bus.wr_req0 = 1; bus.wr_req1 = 1;
      bus.rd_a0 = 3'd1; bus.rd_b0 = 3'd2; bus.rd_a1 = 3'd3; bus.rd_b1 = 3'd4;
      bus.wr_dir0 = 3'd5; bus.wr_dir1 = 3'd6;
      bus.wr_data0 = 64'hAAAA_5555_AAAA_5555; bus.wr_data1 = 64'h1234_5678_9ABC_DEF0;
      cyc(); cyc();
      chk("rst_rd_gnt0", 64'(bus.rd_gnt0), 64'd0);
      chk("rst_rd_gnt1", 64'(bus.rd_gnt1), 64'd0);
      chk("rst_wr_gnt0", 64'(bus.wr_gnt0), 64'd0);
      chk("rst_wr_gnt1", 64'(bus.wr_gnt1), 64'd0);
      chk("rst_sig_read", 64'(bus.bank_signal_read), 64'd0);
      chk("rst_sig_esc", 64'(bus.bank_signal_esc), 64'd0);
      chk("rst_dir_A", 64'(bus.bank_dir_A), 64'd0);
      chk("rst_dir_B", 64'(bus.bank_dir_B), 64'd0);
      chk("rst_dir_esc", 64'(bus.bank_dir_esc), 64'd0);
      chk("rst_data", bus.bank_data, 64'd0);
      chk("rst_vld0", 64'(bus.rd_vld0), 64'd0);
      chk("rst_vld1", 64'(bus.rd_vld1), 64'd0);

      // Vector table: round robin, starvation period, write priority, pulse clear.
      cyc();
      rst_n = 1'b1;
      idle_inputs();
      for (int i = 0; i < 19; i++) begin
         if (i > 0) cyc();
         bus.rd_req0 = tbl[i].rq0; bus.rd_req1 = tbl[i].rq1;
         bus.wr_req0 = tbl[i].wq0; bus.wr_req1 = tbl[i].wq1;
         #1;
         chk($sformatf("v%0d_rd_gnt0", i), 64'(bus.rd_gnt0), 64'(tbl[i].rg0));
         chk($sformatf("v%0d_rd_gnt1", i), 64'(bus.rd_gnt1), 64'(tbl[i].rg1));
         chk($sformatf("v%0d_wr_gnt0", i), 64'(bus.wr_gnt0), 64'(tbl[i].wg0));
         chk($sformatf("v%0d_wr_gnt1", i), 64'(bus.wr_gnt1), 64'(tbl[i].wg1));
         chk($sformatf("v%0d_rd_vld0", i), 64'(bus.rd_vld0), 64'(tbl[i].v0));
         chk($sformatf("v%0d_rd_vld1", i), 64'(bus.rd_vld1), 64'(tbl[i].v1));
      end

      // Preload R3 through port 1 (alone, so granted immediately).
      cyc();
      idle_inputs();
      bus.wr_req1 = 1; bus.wr_dir1 = 3'd3; bus.wr_data1 = 64'h0123_4567_89AB_CDEF;
      #1;
      chk("pre_wr_gnt1", 64'(bus.wr_gnt1), 64'd1);
      chk("pre_dir_esc", 64'(bus.bank_dir_esc), 64'd3);
      chk("pre_data", bus.bank_data, 64'h0123_4567_89AB_CDEF);

      // Read latency: port 1 reads a=3, b=0.
      cyc();
      idle_inputs();
      bus.rd_req1 = 1; bus.rd_a1 = 3'd3; bus.rd_b1 = 3'd0;
      #1;
      chk("lat_rd_gnt1", 64'(bus.rd_gnt1), 64'd1);
      chk("lat_sig_read", 64'(bus.bank_signal_read), 64'd1);
      chk("lat_dir_A", 64'(bus.bank_dir_A), 64'd3);
      cyc();
      idle_inputs();
      #1;
      chk("lat_vld1", 64'(bus.rd_vld1), 64'd1);
      chk("lat_vld0", 64'(bus.rd_vld0), 64'd0);
      chk("lat_vA", va, 64'h0123_4567_89AB_CDEF);
      chk("lat_vB", vb, 64'd0);
      cyc();
      chk("lat_vld1_once", 64'(bus.rd_vld1), 64'd0);

      // Same-cycle write R5 on port 0 and read R5 on port 1.
      bus.wr_req0 = 1; bus.wr_dir0 = 3'd5; bus.wr_data0 = 64'hDEAD_BEEF_0000_0001;
      bus.rd_req1 = 1; bus.rd_a1 = 3'd5; bus.rd_b1 = 3'd3;
      #1;
      chk("rw_wr_gnt0", 64'(bus.wr_gnt0), 64'd1);
      chk("rw_rd_gnt1", 64'(bus.rd_gnt1), 64'd1);
      chk("rw_dir_esc", 64'(bus.bank_dir_esc), 64'd5);
      chk("rw_data", bus.bank_data, 64'hDEAD_BEEF_0000_0001);
      cyc();
      idle_inputs();
      #1;
      chk("rw_vld1", 64'(bus.rd_vld1), 64'd1);
      chk("rw_vA", va, 64'hDEAD_BEEF_0000_0001);
      chk("rw_vB", vb, 64'h0123_4567_89AB_CDEF);

      // Reset asserted on the edge that ends the grant cycle suppresses rd_vld0.
      cyc();
      bus.rd_req0 = 1; bus.rd_a0 = 3'd3; bus.rd_b0 = 3'd5;
      #1;
      chk("mr_rd_gnt0", 64'(bus.rd_gnt0), 64'd1);
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      chk("mr_vld0_supp", 64'(bus.rd_vld0), 64'd0);
      chk("mr_gnt0_rst", 64'(bus.rd_gnt0), 64'd0);
      idle_inputs();
      cyc();
      chk("mr_vld0_hold", 64'(bus.rd_vld0), 64'd0);
      rst_n = 1'b1;
      bus.rd_req0 = 1; bus.rd_a0 = 3'd3; bus.rd_b0 = 3'd5;
      bus.rd_req1 = 1; bus.rd_a1 = 3'd5; bus.rd_b1 = 3'd5;
      #1;
      chk("mr_post_gnt0", 64'(bus.rd_gnt0), 64'd1);
      chk("mr_post_gnt1", 64'(bus.rd_gnt1), 64'd0);
      chk("mr_post_dir_A", 64'(bus.bank_dir_A), 64'd3);
      cyc();
      idle_inputs();
      #1;
      chk("mr_post_vld0", 64'(bus.rd_vld0), 64'd1);
      chk("mr_post_vA", va, 64'h0123_4567_89AB_CDEF);
      chk("mr_post_vB", vb, 64'hDEAD_BEEF_0000_0001);

      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
